// File: rtl/vend_controller.sv
// Multi-item vending controller: shared credit accumulator, per-item prices, change and coin rejection.
// Optional per-item stock tracking is compiled in with VEND_STOCK_EN.
module vend_controller #(
    parameter int                            NUM_ITEMS  = 4,
    parameter int                            PRICE_W    = 6,
    parameter logic [NUM_ITEMS*PRICE_W-1:0]  PRICES     = {6'd6, 6'd5, 6'd4, 6'd3},
    parameter int                            CREDIT_W   = 8,
    parameter int                            STOCK_W    = 4,
    parameter int                            STOCK_INIT = 10,
    localparam int                           ISEL_W     = $clog2(NUM_ITEMS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 nickel_in,
    input  logic                 dime_in,
    input  logic [ISEL_W-1:0]    item_sel,
    input  logic                 vend_req,
    input  logic                 cancel,
    input  logic                 restock,
    input  logic [ISEL_W-1:0]    restock_item,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 dispense,
    output logic [ISEL_W-1:0]    dispense_item,
    output logic                 nickel_out,
    output logic                 coin_reject,
    output logic                 vend_deny,
    output logic                 busy,
    output logic [NUM_ITEMS-1:0] sold_out
);

    localparam int                SUM_W      = ((CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W) + 1;
    localparam logic [SUM_W-1:0]  CREDIT_MAX = SUM_W'((64'd1 << CREDIT_W) - 64'd1);

    // state    | meaning
    // IDLE     | accept coins, vend and cancel requests
    // DISPENSE | one-cycle dispense pulse, stock decrement
    // CHANGE   | nickel_out toggles 1,0 per returned nickel until credit is 0
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_CHANGE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [ISEL_W-1:0]    dispense_item_q, dispense_item_d;
    logic                 dispense_q, dispense_d;
    logic                 nickel_out_q, nickel_out_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 vend_deny_q, vend_deny_d;
    logic                 busy_q, busy_d;
    logic [NUM_ITEMS-1:0] sold_out_q, sold_out_d;

    logic [PRICE_W-1:0]   price_sel;
    logic                 sel_valid;
    logic                 stock_ok;
    logic                 decr_en;
    logic                 coin_any;
    logic [1:0]           coin_val;
    logic                 coin_fits;
    logic [1:0]           coin_acc;
    logic                 coin_rej_idle;
    logic [SUM_W-1:0]     credit_ext;
    logic [SUM_W-1:0]     credit_plus;
    logic                 vend_ok;

    always_comb begin
        price_sel = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_sel == ISEL_W'(i)) begin
                price_sel = PRICES[i*PRICE_W +: PRICE_W];
                sel_valid = 1'b1;
            end
        end
    end

    // A simultaneous nickel is always refused; the dime alone is checked for overflow.
    always_comb begin
        coin_any      = nickel_in | dime_in;
        coin_val      = dime_in ? 2'd2 : (nickel_in ? 2'd1 : 2'd0);
        credit_ext    = SUM_W'(credit_q);
        coin_fits     = (credit_ext + SUM_W'(coin_val)) <= CREDIT_MAX;
        coin_acc      = coin_fits ? coin_val : 2'd0;
        coin_rej_idle = (nickel_in & dime_in) | (coin_any & ~coin_fits);
        credit_plus   = credit_ext + SUM_W'(coin_acc);
        vend_ok       = sel_valid && (credit_ext >= SUM_W'(price_sel)) && stock_ok;
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

    always_comb begin
        stock_ok = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_sel == ISEL_W'(i)) begin
                stock_ok = (stock_q[i] != '0);
            end
        end
    end

    // Refill overrides a same-cycle dispense decrement of the same item.
    always_comb begin
        sold_out_d = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (decr_en && (dispense_item_q == ISEL_W'(i)) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - 1'b1;
            end
            if (restock && (restock_item == ISEL_W'(i))) begin
                stock_d[i] = '1;
            end
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end
`else
    logic unused_restock;

    assign unused_restock = ^{restock, restock_item, decr_en};

    always_comb begin
        stock_ok   = 1'b1;
        sold_out_d = '0;
    end
`endif

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        dispense_item_d = dispense_item_q;
        dispense_d      = 1'b0;
        nickel_out_d    = 1'b0;
        coin_reject_d   = 1'b0;
        vend_deny_d     = 1'b0;
        decr_en         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                credit_d      = CREDIT_W'(credit_plus);
                coin_reject_d = coin_rej_idle;
                if (cancel) begin
                    if (credit_plus != '0) begin
                        state_d      = S_CHANGE;
                        nickel_out_d = 1'b1;
                    end
                end else if (vend_req) begin
                    if (vend_ok) begin
                        credit_d        = CREDIT_W'(credit_plus - SUM_W'(price_sel));
                        dispense_item_d = item_sel;
                        dispense_d      = 1'b1;
                        state_d         = S_DISPENSE;
                    end else begin
                        vend_deny_d = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                coin_reject_d = coin_any;
                decr_en       = 1'b1;
                if (credit_q != '0) begin
                    state_d      = S_CHANGE;
                    nickel_out_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                coin_reject_d = coin_any;
                if (nickel_out_q) begin
                    credit_d = credit_q - 1'b1;
                end else if (credit_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    nickel_out_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            credit_q        <= '0;
            dispense_item_q <= '0;
            dispense_q      <= 1'b0;
            nickel_out_q    <= 1'b0;
            coin_reject_q   <= 1'b0;
            vend_deny_q     <= 1'b0;
            busy_q          <= 1'b0;
            sold_out_q      <= '0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            dispense_item_q <= dispense_item_d;
            dispense_q      <= dispense_d;
            nickel_out_q    <= nickel_out_d;
            coin_reject_q   <= coin_reject_d;
            vend_deny_q     <= vend_deny_d;
            busy_q          <= busy_d;
            sold_out_q      <= sold_out_d;
        end
    end

    assign credit        = credit_q;
    assign dispense      = dispense_q;
    assign dispense_item = dispense_item_q;
    assign nickel_out    = nickel_out_q;
    assign coin_reject   = coin_reject_q;
    assign vend_deny     = vend_deny_q;
    assign busy          = busy_q;
    assign sold_out      = sold_out_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: default build, a 3-bit credit build and a STOCK_INIT=1 build.
module tb_vend_controller;

    logic       clock, reset;
    logic       nickel_in, dime_in, vend_req, cancel, restock;
    logic [1:0] item_sel, restock_item;

    logic [7:0] credit0;  logic dispense0, nickel_out0, coin_reject0, vend_deny0, busy0;
    logic [1:0] dispense_item0; logic [3:0] sold_out0;
    logic [2:0] credit3;  logic dispense3, nickel_out3, coin_reject3, vend_deny3, busy3;
    logic [1:0] dispense_item3; logic [3:0] sold_out3;
    logic [7:0] credit_s; logic dispense_s, nickel_out_s, coin_reject_s, vend_deny_s, busy_s;
    logic [1:0] dispense_item_s; logic [3:0] sold_out_s;

    int vectors = 0;
    int miscompares = 0;

`ifdef VEND_STOCK_EN
    localparam bit STOCK_EN = 1'b1;
`else
    localparam bit STOCK_EN = 1'b0;
`endif

    vend_controller u_dut0 (
        .clock(clock), .reset(reset), .nickel_in(nickel_in), .dime_in(dime_in),
        .item_sel(item_sel), .vend_req(vend_req), .cancel(cancel), .restock(restock),
        .restock_item(restock_item), .credit(credit0), .dispense(dispense0),
        .dispense_item(dispense_item0), .nickel_out(nickel_out0), .coin_reject(coin_reject0),
        .vend_deny(vend_deny0), .busy(busy0), .sold_out(sold_out0));

    vend_controller #(.CREDIT_W(3)) u_dut3 (
        .clock(clock), .reset(reset), .nickel_in(nickel_in), .dime_in(dime_in),
        .item_sel(item_sel), .vend_req(vend_req), .cancel(cancel), .restock(restock),
        .restock_item(restock_item), .credit(credit3), .dispense(dispense3),
        .dispense_item(dispense_item3), .nickel_out(nickel_out3), .coin_reject(coin_reject3),
        .vend_deny(vend_deny3), .busy(busy3), .sold_out(sold_out3));

    vend_controller #(.STOCK_INIT(1)) u_dut_s (
        .clock(clock), .reset(reset), .nickel_in(nickel_in), .dime_in(dime_in),
        .item_sel(item_sel), .vend_req(vend_req), .cancel(cancel), .restock(restock),
        .restock_item(restock_item), .credit(credit_s), .dispense(dispense_s),
        .dispense_item(dispense_item_s), .nickel_out(nickel_out_s), .coin_reject(coin_reject_s),
        .vend_deny(vend_deny_s), .busy(busy_s), .sold_out(sold_out_s));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        nickel_in = 0; dime_in = 0; vend_req = 0; cancel = 0; restock = 0;
        item_sel = 0; restock_item = 0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic cyc(input logic n, input logic d, input logic v, input logic c, input logic rs);
        nickel_in = n; dime_in = d; vend_req = v; cancel = c; restock = rs;
        @(posedge clock); #1;
        nickel_in = 0; dime_in = 0; vend_req = 0; cancel = 0; restock = 0;
    endtask

    task automatic drain0(output int pulses, output int cycles);
        pulses = 0; cycles = 0;
        while (busy0 && cycles < 64) begin
            if (nickel_out0) pulses++;
            cycles++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        do_reset(); #1;
        vectors++; if (credit0 !== 8'd0) begin miscompares++; $display("FAIL reset_credit: got %0d want 0", credit0); end
        vectors++; if ({dispense0, nickel_out0, coin_reject0, vend_deny0, busy0} !== 5'b0) begin miscompares++;
            $display("FAIL reset_flags: got %b want 00000", {dispense0, nickel_out0, coin_reject0, vend_deny0, busy0}); end
        vectors++; if (dispense_item0 !== 2'd0) begin miscompares++; $display("FAIL reset_item: got %0d want 0", dispense_item0); end
        vectors++; if (sold_out0 !== 4'b0) begin miscompares++; $display("FAIL reset_sold_out: got %b want 0000", sold_out0); end
    endtask

    task automatic test_vend_with_change();
        do_reset();
        cyc(0, 1, 0, 0, 0);
        vectors++; if (credit0 !== 8'd2) begin miscompares++; $display("FAIL vwc_dime1: credit %0d want 2", credit0); end
        cyc(0, 1, 0, 0, 0);
        vectors++; if (credit0 !== 8'd4) begin miscompares++; $display("FAIL vwc_dime2: credit %0d want 4", credit0); end
        item_sel = 2'd0;
        cyc(0, 0, 1, 0, 0);
        vectors++; if ({dispense0, busy0, dispense_item0, credit0} !== {1'b1, 1'b1, 2'd0, 8'd1}) begin miscompares++;
            $display("FAIL vwc_dispense: disp=%b busy=%b item=%0d credit=%0d want 1 1 0 1", dispense0, busy0, dispense_item0, credit0); end
        cyc(0, 0, 0, 0, 0);
        vectors++; if ({dispense0, nickel_out0, credit0} !== {1'b0, 1'b1, 8'd1}) begin miscompares++;
            $display("FAIL vwc_change_hi: disp=%b nout=%b credit=%0d want 0 1 1", dispense0, nickel_out0, credit0); end
        cyc(0, 0, 0, 0, 0);
        vectors++; if ({nickel_out0, busy0, credit0} !== {1'b0, 1'b1, 8'd0}) begin miscompares++;
            $display("FAIL vwc_change_lo: nout=%b busy=%b credit=%0d want 0 1 0", nickel_out0, busy0, credit0); end
        cyc(0, 0, 0, 0, 0);
        vectors++; if ({nickel_out0, busy0} !== 2'b00) begin miscompares++;
            $display("FAIL vwc_idle: nout=%b busy=%b want 0 0", nickel_out0, busy0); end
    endtask

    task automatic test_deny_and_cancel();
        cyc(1, 0, 0, 0, 0);
        item_sel = 2'd3;
        cyc(0, 0, 1, 0, 0);
        vectors++; if ({vend_deny0, dispense0, busy0, credit0} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin miscompares++;
            $display("FAIL deny: deny=%b disp=%b busy=%b credit=%0d want 1 0 0 1", vend_deny0, dispense0, busy0, credit0); end
        cyc(0, 0, 0, 0, 0);
        vectors++; if (vend_deny0 !== 1'b0) begin miscompares++; $display("FAIL deny_one_cycle: deny=%b want 0", vend_deny0); end
        cyc(0, 0, 0, 1, 0);
        vectors++; if ({nickel_out0, busy0, credit0} !== {1'b1, 1'b1, 8'd1}) begin miscompares++;
            $display("FAIL cancel_hi: nout=%b busy=%b credit=%0d want 1 1 1", nickel_out0, busy0, credit0); end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        vectors++; if ({nickel_out0, busy0, credit0} !== {1'b0, 1'b0, 8'd0}) begin miscompares++;
            $display("FAIL cancel_done: nout=%b busy=%b credit=%0d want 0 0 0", nickel_out0, busy0, credit0); end
    endtask

    task automatic test_exact_and_same_cycle();
        int pulses, cycles;
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        item_sel = 2'd0;
        cyc(0, 0, 1, 0, 0);
        vectors++; if ({dispense0, busy0, credit0} !== {1'b1, 1'b1, 8'd0}) begin miscompares++;
            $display("FAIL exact_disp: disp=%b busy=%b credit=%0d want 1 1 0", dispense0, busy0, credit0); end
        cyc(0, 0, 0, 0, 0);
        vectors++; if ({dispense0, busy0, nickel_out0} !== 3'b000) begin miscompares++;
            $display("FAIL exact_busy_1cyc: disp=%b busy=%b nout=%b want 0 0 0", dispense0, busy0, nickel_out0); end
        // credit 2, price 3: a same-cycle dime does not count toward the price check
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        vectors++; if ({vend_deny0, dispense0, credit0} !== {1'b1, 1'b0, 8'd4}) begin miscompares++;
            $display("FAIL precoin_price: deny=%b disp=%b credit=%0d want 1 0 4", vend_deny0, dispense0, credit0); end
        cyc(0, 0, 1, 1, 0);
        vectors++; if ({vend_deny0, dispense0, nickel_out0, busy0} !== 4'b0011) begin miscompares++;
            $display("FAIL cancel_priority: deny=%b disp=%b nout=%b busy=%b want 0 0 1 1", vend_deny0, dispense0, nickel_out0, busy0); end
        drain0(pulses, cycles);
        vectors++; if ({pulses, cycles} !== {32'd4, 32'd8}) begin miscompares++;
            $display("FAIL refund4: pulses=%0d cycles=%0d want 4 8", pulses, cycles); end
        cyc(0, 0, 0, 1, 0);
        vectors++; if ({busy0, nickel_out0, credit0} !== {1'b0, 1'b0, 8'd0}) begin miscompares++;
            $display("FAIL cancel_zero: busy=%b nout=%b credit=%0d want 0 0 0", busy0, nickel_out0, credit0); end
    endtask

    task automatic test_coin_collision();
        do_reset();
        cyc(1, 1, 0, 0, 0);
        vectors++; if ({coin_reject0, credit0} !== {1'b1, 8'd2}) begin miscompares++;
            $display("FAIL collide: rej=%b credit=%0d want 1 2", coin_reject0, credit0); end
        cyc(0, 0, 0, 1, 0);
        vectors++; if ({coin_reject0, nickel_out0, credit0} !== {1'b0, 1'b1, 8'd2}) begin miscompares++;
            $display("FAIL collide_cancel: rej=%b nout=%b credit=%0d want 0 1 2", coin_reject0, nickel_out0, credit0); end
        cyc(0, 1, 0, 0, 0);
        vectors++; if ({coin_reject0, nickel_out0, credit0} !== {1'b1, 1'b0, 8'd1}) begin miscompares++;
            $display("FAIL change_reject: rej=%b nout=%b credit=%0d want 1 0 1", coin_reject0, nickel_out0, credit0); end
        cyc(0, 0, 0, 0, 0);
        vectors++; if ({coin_reject0, nickel_out0, credit0} !== {1'b0, 1'b1, 8'd1}) begin miscompares++;
            $display("FAIL change_resume: rej=%b nout=%b credit=%0d want 0 1 1", coin_reject0, nickel_out0, credit0); end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        vectors++; if ({busy0, credit0} !== {1'b0, 8'd0}) begin miscompares++;
            $display("FAIL change_end: busy=%b credit=%0d want 0 0", busy0, credit0); end
    endtask

    task automatic test_credit_overflow();
        int pulses, cycles;
        logic [2:0] exp_c [3] = '{3'd2, 3'd4, 3'd6};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            vectors++; if ({coin_reject3, credit3} !== {1'b0, exp_c[i]}) begin miscompares++;
                $display("FAIL ovf_dime%0d: rej=%b credit=%0d want 0 %0d", i, coin_reject3, credit3, exp_c[i]); end
        end
        cyc(0, 1, 0, 0, 0);
        vectors++; if ({coin_reject3, credit3} !== {1'b1, 3'd6}) begin miscompares++;
            $display("FAIL ovf_reject: rej=%b credit=%0d want 1 6", coin_reject3, credit3); end
        cyc(0, 0, 0, 1, 0);
        pulses = 0; cycles = 0;
        while (busy3 && cycles < 64) begin
            if (nickel_out3) pulses++;
            cycles++;
            @(posedge clock); #1;
        end
        vectors++; if ({pulses, cycles, credit3} !== {32'd6, 32'd12, 3'd0}) begin miscompares++;
            $display("FAIL ovf_refund: pulses=%0d cycles=%0d credit=%0d want 6 12 0", pulses, cycles, credit3); end
    endtask

    task automatic test_stock();
        do_reset();
        item_sel = 2'd1; restock_item = 2'd1;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        vectors++; if ({dispense_s, dispense_item_s} !== {1'b1, 2'd1}) begin miscompares++;
            $display("FAIL stock_vend1: disp=%b item=%0d want 1 1", dispense_s, dispense_item_s); end
        cyc(0, 0, 0, 0, 0);
        vectors++; if (sold_out_s !== (STOCK_EN ? 4'b0010 : 4'b0000)) begin miscompares++;
            $display("FAIL stock_sold_out: got %b want %b", sold_out_s, STOCK_EN ? 4'b0010 : 4'b0000); end
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        vectors++; if ({vend_deny_s, dispense_s, credit_s} !== {STOCK_EN, ~STOCK_EN, STOCK_EN ? 8'd4 : 8'd0}) begin miscompares++;
            $display("FAIL stock_vend2: deny=%b disp=%b credit=%0d", vend_deny_s, dispense_s, credit_s); end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        vectors++; if (sold_out_s !== 4'b0000) begin miscompares++; $display("FAIL restock: sold_out %b want 0000", sold_out_s); end
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        vectors++; if ({dispense_s, vend_deny_s, credit_s} !== {1'b1, 1'b0, STOCK_EN ? 8'd4 : 8'd0}) begin miscompares++;
            $display("FAIL stock_vend3: disp=%b deny=%b credit=%0d", dispense_s, vend_deny_s, credit_s); end
    endtask

    task automatic test_reset_mid_change();
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        vectors++; if ({nickel_out0, busy0, credit0} !== {1'b1, 1'b1, 8'd3}) begin miscompares++;
            $display("FAIL mid_pre: nout=%b busy=%b credit=%0d want 1 1 3", nickel_out0, busy0, credit0); end
        #2 reset = 1'b1;
        #1;
        vectors++; if ({nickel_out0, busy0, credit0} !== {1'b0, 1'b0, 8'd0}) begin miscompares++;
            $display("FAIL mid_reset: nout=%b busy=%b credit=%0d want 0 0 0", nickel_out0, busy0, credit0); end
        @(negedge clock);
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0);
        vectors++; if ({nickel_out0, busy0, coin_reject0, credit0} !== {1'b0, 1'b0, 1'b0, 8'd1}) begin miscompares++;
            $display("FAIL mid_idle: nout=%b busy=%b rej=%b credit=%0d want 0 0 0 1", nickel_out0, busy0, coin_reject0, credit0); end
    endtask

    initial begin
        test_reset();
        test_vend_with_change();
        test_deny_and_cancel();
        test_exact_and_same_cycle();
        test_coin_collision();
        test_credit_overflow();
        test_stock();
        test_reset_mid_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Parametrised multi-item vending controller that generalises the fixed per-item nickel/dime FSMs into one shared credit accumulator. It supports a configurable item count with per-item prices, explicit vend and cancel requests, multi-nickel change return and coin rejection. It sits between the coin acceptor / keypad front end and the dispense and change actuators, and replaces the per-item instances plus the output mux.

## Interface
- NUM_ITEMS, 4: number of selectable items, at least 2.
- PRICE_W, 6: width of one price field, in nickel units.
- PRICES, {6'd6,6'd5,6'd4,6'd3}: packed NUM_ITEMS×PRICE_W price table. Item 0 is in the LSBs. Defaults are 15/20/25/30 cents.
- CREDIT_W, 8: credit register width, in nickels. CREDIT_MAX = 2^CREDIT_W−1.
- STOCK_W, 4 / STOCK_INIT, 10: per-item stock counter width and reset value.
- ISEL_W = $clog2(NUM_ITEMS): derived.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- nickel_in  in  1  one-cycle pulse per nickel inserted.
- dime_in  in  1  one-cycle pulse per dime inserted.
- item_sel  in  ISEL_W  item index, sampled with vend_req.
- vend_req  in  1  one-cycle vend request pulse.
- cancel  in  1  one-cycle request to refund all credit.
- restock  in  1  pulse that refills restock_item to 2^STOCK_W−1.
- restock_item  in  ISEL_W  item to refill.
- credit  out  CREDIT_W  current credit, registered, in nickels.
- dispense  out  1  one-cycle pulse, one per item vended.
- dispense_item  out  ISEL_W  vended index, valid while dispense is high.
- nickel_out  out  1  change pulse; each pulse is one nickel returned.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- vend_deny  out  1  one-cycle pulse when a vend request is refused.
- busy  out  1  high in DISPENSE and CHANGE.
- sold_out  out  NUM_ITEMS  bit i high when stock[i]==0.

## Operation
- FSM states: IDLE, DISPENSE, CHANGE. Reset state is IDLE.
- IDLE coin handling:
  - Nickel adds 1 and dime adds 2 to credit.
  - If nickel and dime arrive in the same cycle, the dime is accepted and the nickel is rejected (coin_reject).
  - If a coin would push credit above CREDIT_MAX, the coin is rejected and credit is unchanged.
- IDLE vend_req:
  - Accepted only if all three hold: item_sel<NUM_ITEMS, credit≥PRICES[item_sel], and stock>0.
  - On accept: credit ← credit−price (+accepted coin), the item is latched, and the FSM goes to DISPENSE.
  - Otherwise vend_deny pulses and the state is unchanged.
  - Price is compared against the pre-coin credit of the same cycle.
- IDLE cancel:
  - Has priority over vend_req in the same cycle; the vend is dropped silently.
  - With credit>0 (after adding a same-cycle coin), the FSM goes to CHANGE.
  - With credit==0, cancel is a no-op.
- DISPENSE (exactly 1 cycle): dispense=1, dispense_item=latched index, and the stock of that item decrements. Next state is CHANGE if credit>0, else IDLE.
- CHANGE:
  - nickel_out alternates 1,0,1,0… starting high on the first CHANGE cycle.
  - Credit decrements by 1 on each high cycle.
  - The FSM exits to IDLE in the cycle after the last low phase, once credit==0.
- In DISPENSE and CHANGE, every coin pulses coin_reject, and vend_req and cancel are ignored (no deny pulse).
- restock is serviced in any state. If it targets the same item as a DISPENSE decrement in the same cycle, the refill wins.
- Reset mid-operation: credit is cleared, any change in progress is forfeited, and all outputs go low.

## Timing
- Reset values: credit=0, dispense=0, dispense_item=0, nickel_out=0, coin_reject=0, vend_deny=0, busy=0, all stock=STOCK_INIT, sold_out=0.
- All outputs are registered.
- Coin at edge N: credit updates and any coin_reject is visible after edge N.
- vend_req at edge N:
  - Accepted: dispense is high during cycle N+1.
  - Refused: vend_deny is high during cycle N+1.
- Change of k nickels takes 2k cycles of CHANGE; busy drops after the last one.
- Vend with exact credit: busy lasts 1 cycle.

## Configuration
- VEND_STOCK_EN defined:
  - Per-item stock counters are implemented, and a vend of an item at stock 0 is denied.
  - restock and restock_item are honoured, and sold_out is live.
- VEND_STOCK_EN undefined:
  - Stock counters are removed and stock is treated as unlimited.
  - restock and restock_item are ignored, and sold_out is constant 0.

## Test plan
- Default params: after reset, dime, dime, vend_req with item_sel=0 (price 3). Required: credit goes 2→4, then 1 after the vend. dispense pulses with item 0, then one nickel_out pulse, credit=0, back to IDLE.
- nickel, vend_req with item_sel=3 (price 6). Required: vend_deny pulse, credit stays 1. Then cancel gives one nickel_out pulse and credit=0.
- nickel_in and dime_in high in the same cycle. Required: credit +2, coin_reject pulse. A dime during CHANGE pulses coin_reject and leaves the change sequence unaltered.
- CREDIT_W=3: insert 4 dimes. Required: credit 2→4→6, then the fourth dime is rejected and credit stays 6. cancel then gives 6 nickel_out pulses over 12 cycles.
- VEND_STOCK_EN, STOCK_INIT=1: two paid vends of item 1. Required: the second is denied and sold_out[1]=1. After restock with restock_item=1, sold_out[1]=0 and the vend succeeds.
- Assert reset during CHANGE with credit 3. Required: nickel_out, busy and credit are 0 immediately, and the FSM is in IDLE after reset releases.
